// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline datapath.
// Provides the datapath width, register address width, register count,
// the hardwired-zero register index and the word / register-address types.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_core.sv
// Architectural register file: 2**ADDR_W entries, one write port, two
// combinational read ports. Entry 0 is hardwired to zero.
// Optional macro REGFILE_BYPASS_EN: a read of the register being written in
// the same cycle returns the write data (write-first).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears array)
//   we, waddr, wdata  write port (we already excludes address 0)
//   ra1/ra2 -> rd1/rd2  combinational read ports
module regfile_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    import mips_pkg::*;

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_wr_ok;

    assign w_wr_ok = we && (waddr != ADDR_W'(REG_ZERO));

    // Array storage; entry 0 is cleared by reset and never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Read port 1
    always_comb begin
        rd1 = r_regs[ra1];
`ifdef REGFILE_BYPASS_EN
        // Bypass is suppressed during reset so reads stay zero.
        if (w_wr_ok && !rst && (ra1 == waddr)) begin
            rd1 = wdata;
        end
`endif
        if (ra1 == ADDR_W'(REG_ZERO)) begin
            rd1 = '0;
        end
    end

    // Read port 2
    always_comb begin
        rd2 = r_regs[ra2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_ok && !rst && (ra2 == waddr)) begin
            rd2 = wdata;
        end
`endif
        if (ra2 == ADDR_W'(REG_ZERO)) begin
            rd2 = '0;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file.
// Selects load data or ALU result, qualifies the write enable (no writes to
// $0), commits into regfile_core, exports the writeback bus to forwarding and
// counts committed writes.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read bypass in the
// register file.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rdata_in, alu_in           MEM/WB load data and ALU result
//   rd_in, RegWrite_in, MemToReg_in  MEM/WB destination and controls
//   ra1, ra2 -> rd1, rd2       decode-stage read ports (combinational)
//   wb_data, wb_rd, wb_we      writeback bus (combinational)
//   wb_count                   committed-write counter (wraps)
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              wb_we,
    output logic [31:0]       wb_count
);
    import mips_pkg::*;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_we;
    logic [31:0]       r_wb_count;

    // Writeback mux and write-enable qualification
    assign w_wb_data = MemToReg_in ? rdata_in : alu_in;
    assign w_wb_we   = RegWrite_in && (rd_in != ADDR_W'(REG_ZERO));

    assign wb_data  = w_wb_data;
    assign wb_rd    = rd_in;
    assign wb_we    = w_wb_we;
    assign wb_count = r_wb_count;

    // Committed-write counter; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (w_wb_we) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst   (reset),
        .we    (w_wb_we),
        .waddr (rd_in),
        .wdata (w_wb_data),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value (load data or ALU result), and commits it to a 32-entry register file. Serves the two decode-stage read ports and exports the writeback bus to the forwarding unit. Optionally bypasses same-cycle writes to the read ports.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high
- rdata_in  input  DATA_W  load data from MEM/WB
- alu_in  input  DATA_W  ALU result from MEM/WB
- rd_in  input  ADDR_W  destination register from MEM/WB
- RegWrite_in  input  1  write enable from MEM/WB
- MemToReg_in  input  1  1 = write rdata_in, 0 = write alu_in
- ra1, ra2  input  ADDR_W  decode-stage read addresses
- rd1, rd2  output  DATA_W  read data (combinational)
- wb_data  output  DATA_W  selected writeback value (combinational)
- wb_rd  output  ADDR_W  equals rd_in
- wb_we  output  1  RegWrite_in && (rd_in != 0)
- wb_count  output  32  count of committed register writes

## Operation
- wb_data = MemToReg_in ? rdata_in : alu_in.
- Commit: at posedge clk, if wb_we, regs[rd_in] <= wb_data.
- Register 0: never written; always reads 0. RegWrite_in with rd_in = 0 is a no-op: no write, wb_we = 0, no count.
- Reads: rd1 = regs[ra1], rd2 = regs[ra2], combinational, 0 for address 0.
- wb_count: increments by 1 at posedge clk when wb_we; 32-bit, wraps 0xFFFFFFFF -> 0 silently.
- Both read ports may address the same register, including the one being written; each port resolves independently.

## Timing
- Reset: all registers 0, wb_count 0, effective immediately (asynchronous), released synchronously to the next edge. While reset is high, no commit or count occurs, rd1/rd2 read 0.
- Reset mid-operation: a write presented in the same cycle that reset asserts is discarded.
- Write latency: visible in the array 1 cycle after presentation (post-edge).
- wb_data/wb_rd/wb_we: same-cycle combinational function of inputs; no latency.
- Read latency: 0 cycles (combinational from ra1/ra2 and array state).

## Configuration
- REGFILE_BYPASS_EN defined: if wb_we and raX == rd_in, rdX = wb_data in the same cycle (write-first). Decode reading the register written by WB sees the new value with no stall.
- Undefined: rdX returns the pre-write array value in that cycle; the hazard unit must stall decode one extra cycle for WB->ID dependencies.
- Address 0 reads 0 in both configurations.

## Structure
- Shared package mips_pkg: DATA_W, ADDR_W, NUM_REGS = 32, REG_ZERO = 0 constants; reg_addr_t and word_t typedefs.
- Sub-module regfile_core: array, async reset, single write port, two read ports, bypass logic under the macro. wb_regfile holds the writeback mux, the wb_we qualification and wb_count.

## Test plan
- Reset: assert reset with nonzero inputs -> rd1/rd2 = 0 for all 32 addresses, wb_count = 0.
- ALU writeback: alu_in = 0x0000_1234, MemToReg_in = 0, rd_in = 5, RegWrite_in = 1 for one cycle -> wb_data = 0x1234 in that cycle; next cycle ra1 = 5 reads 0x1234, wb_count = 1.
- Load writeback and $0: rdata_in = 0xDEAD_BEEF, MemToReg_in = 1, rd_in = 0, RegWrite_in = 1 -> wb_we = 0, ra1 = 0 reads 0, wb_count unchanged.
- Same-cycle read of write target: regs[7] = 0x11, write 0x22 to rd 7 with ra1 = ra2 = 7 -> with REGFILE_BYPASS_EN rd1 = rd2 = 0x22 that cycle; without, 0x11 that cycle and 0x22 next.
- Counter wrap: force wb_count to 0xFFFF_FFFF, one valid write -> wb_count = 0.
- Reset mid-write: assert reset in the same cycle as a write of 0x55 to rd 3 -> regs[3] = 0 after reset release, wb_count = 0.
